// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: sizes, FSM states and
// a one-hot helper used by the top level.
package rr_mux_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int HOLD_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Decode a requester index into a one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage : rr_mux_arbiter_pkg

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin picker: searches req starting one past the last
// winner and wrapping, so the last owner is always considered last.
module rr_pick
    import rr_mux_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last_winner,
    output logic               valid,
    output logic [SEL_W-1:0]   winner
);

    logic [SEL_W-1:0] cand;

    // First active request at offsets 1..NUM_REQ from last_winner wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            // Offset NUM_REQ truncates to 0, i.e. the last winner itself.
            cand = last_winner + SEL_W'(i);
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter driving a shared 1-bit mux. A tenure
// ends on request drop, done from the owner, or MAX_HOLD expiry; every
// tenure is followed by a one-cycle GAP before the next arbitration.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    // Maximum grant tenure in cycles; legal range 2..255.
    parameter int unsigned MAX_HOLD = 8
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    input  logic [NUM_REQ-1:0] data_in,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               mux_out,
    output logic               busy,
    output logic               preempt
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    last_winner_q, last_winner_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                busy_q, busy_d;
    logic                preempt_q, preempt_d;
    // Held low for the first edge after reset release so arbitration starts
    // on the second edge.
    logic                arb_en_q, arb_en_d;

    logic                pick_valid;
    logic [SEL_W-1:0]    pick_winner;
    logic                owner_release;
    logic                owner_expire;

    rr_pick u_pick (
        .req         (req),
        .last_winner (last_winner_q),
        .valid       (pick_valid),
        .winner      (pick_winner)
    );

    // End-of-tenure causes; only the current owner's req/done are looked at.
    always_comb begin
        owner_release = !req[sel_q] || done[sel_q];
        owner_expire  = (hold_cnt_q == HOLD_LAST);
    end

    // Next-state and next-output logic for the IDLE/GRANT/GAP machine.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        grant_d       = grant_q;
        sel_d         = sel_q;
        last_winner_d = last_winner_q;
        hold_cnt_d    = hold_cnt_q;
        preempt_d     = 1'b0;
        arb_en_d      = 1'b1;

        case (state_q)
            IDLE: begin
                if (arb_en_q && pick_valid) begin
                    state_d    = GRANT;
                    grant_d    = onehot(pick_winner);
                    sel_d      = pick_winner;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (owner_release || owner_expire) begin
                    state_d       = GAP;
                    grant_d       = '0;
                    last_winner_d = sel_q;
                    // Release by the owner outranks expiry on the same edge.
                    preempt_d     = owner_expire && !owner_release;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset leaves requester 0 with first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            sel_q         <= '0;
            last_winner_q <= SEL_W'(NUM_REQ - 1);
            hold_cnt_q    <= '0;
            busy_q        <= 1'b0;
            preempt_q     <= 1'b0;
            arb_en_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, independent of statement order.
            state_q       <= state_d;
            grant_q       <= grant_d;
            sel_q         <= sel_d;
            last_winner_q <= last_winner_d;
            hold_cnt_q    <= hold_cnt_d;
            busy_q        <= busy_d;
            preempt_q     <= preempt_d;
            arb_en_q      <= arb_en_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;
    assign mux_out = (state_q == GRANT) ? data_in[sel_q] : 1'b0;

endmodule : rr_mux_arbiter

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter. Two instances share all inputs:
// dut8 (MAX_HOLD=8) and dut2 (MAX_HOLD=2). Outputs are compared as a packed
// vector {grant, sel, busy, preempt, mux_out}.
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] data_in;

    logic [3:0] grant8, grant2;
    logic [1:0] sel8, sel2;
    logic       mux8, mux2;
    logic       busy8, busy2;
    logic       pre8, pre2;

    int n_checks = 0;
    int n_pass   = 0;

    rr_mux_arbiter #(.MAX_HOLD(8)) dut8 (
        .clk (clk), .rst_n (rst_n), .req (req), .done (done), .data_in (data_in),
        .grant (grant8), .sel (sel8), .mux_out (mux8), .busy (busy8), .preempt (pre8)
    );

    rr_mux_arbiter #(.MAX_HOLD(2)) dut2 (
        .clk (clk), .rst_n (rst_n), .req (req), .done (done), .data_in (data_in),
        .grant (grant2), .sel (sel2), .mux_out (mux2), .busy (busy2), .preempt (pre2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grant must be one-hot-or-zero and agree with sel on both instances.
    a_onehot8: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant8) && (grant8 == 4'b0 || grant8[sel8]))
        else $error("FAIL onehot8: grant=%b sel=%0d, want one-hot matching sel", grant8, sel8);
    a_onehot2: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant2) && (grant2 == 4'b0 || grant2[sel2]))
        else $error("FAIL onehot2: grant=%b sel=%0d, want one-hot matching sel", grant2, sel2);

    function automatic logic [8:0] obs(input bit use2);
        if (use2) return {grant2, sel2, busy2, pre2, mux2};
        return {grant8, sel8, busy8, pre8, mux8};
    endfunction

    function automatic logic [8:0] pack_vec(input logic [3:0] g, input logic [1:0] s,
                                            input logic b, input logic p, input logic m);
        return {g, s, b, p, m};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset over two edges, then release with the given request vector.
    task automatic do_reset(input logic [3:0] r);
        rst_n   = 1'b0;
        req     = 4'b0;
        done    = 4'b0;
        data_in = 4'b0;
        step();
        step();
        rst_n = 1'b1;
        req   = r;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        logic [8:0] want;
        rst_n   = 1'b0;
        req     = 4'b1111;
        done    = 4'b0;
        data_in = 4'b1111;
        #1;
        for (int c = 0; c < 3; c++) begin
            for (int d = 0; d < 2; d++) begin
                got  = obs(d == 1);
                want = pack_vec(4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
                n_checks++;
                if (got !== want) $display("FAIL reset_hold dut%0d c%0d: got %b want %b", d, c, got, want);
                else n_pass++;
            end
            step();
        end
        rst_n = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            got  = obs(d == 1);
            want = pack_vec(4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (got !== want) $display("FAIL reset_first_edge dut%0d: got %b want %b", d, got, want);
            else n_pass++;
        end
        step();
        for (int d = 0; d < 2; d++) begin
            got  = obs(d == 1);
            want = pack_vec(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
            n_checks++;
            if (got !== want) $display("FAIL reset_second_edge dut%0d: got %b want %b", d, got, want);
            else n_pass++;
        end
    endtask

    // Continuous requests: expect owners in round-robin order, full tenures,
    // one preempt per tenure and two grant-free cycles between tenures.
    task automatic test_rotation(input bit use2, input int tenure, input int modn,
                                 input logic [3:0] r, input int n_ten);
        logic [8:0] got;
        logic [8:0] want;
        logic [1:0] k;
        logic [3:0] one;
        int         n_pre;
        one   = 4'b0001;
        n_pre = 0;
        do_reset(r);
        data_in = 4'b0110;
        step();
        step();
        for (int t = 0; t < n_ten; t++) begin
            k = 2'(t % modn);
            for (int c = 0; c < tenure; c++) begin
                got  = obs(use2);
                want = pack_vec(one << k, k, 1'b1, 1'b0, data_in[k]);
                n_checks++;
                if (got !== want) $display("FAIL rotation_grant h%0d t%0d c%0d: got %b want %b", tenure, t, c, got, want);
                else n_pass++;
                step();
            end
            got = obs(use2);
            if (got[1]) n_pre++;
            want = pack_vec(4'b0, k, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (got !== want) $display("FAIL rotation_gap h%0d t%0d: got %b want %b", tenure, t, got, want);
            else n_pass++;
            step();
            got  = obs(use2);
            want = pack_vec(4'b0, k, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (got !== want) $display("FAIL rotation_idle h%0d t%0d: got %b want %b", tenure, t, got, want);
            else n_pass++;
            step();
        end
        n_checks++;
        if (n_pre !== n_ten) $display("FAIL rotation_preempt_count h%0d: got %0d want %0d", tenure, n_pre, n_ten);
        else n_pass++;
        req = 4'b0;
    endtask

    task automatic test_single_drop();
        logic [8:0] got;
        logic [8:0] want;
        do_reset(4'b0);
        step();
        step();
        step();
        req = 4'b0100;
        got  = obs(0);
        want = pack_vec(4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got !== want) $display("FAIL single_pre: got %b want %b", got, want);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            step();
            got  = obs(0);
            want = pack_vec(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (got !== want) $display("FAIL single_grant c%0d: got %b want %b", c, got, want);
            else n_pass++;
        end
        req = 4'b0;
        step();
        got  = obs(0);
        want = pack_vec(4'b0, 2'd2, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (got !== want) $display("FAIL single_gap: got %b want %b", got, want);
        else n_pass++;
        step();
        got  = obs(0);
        want = pack_vec(4'b0, 2'd2, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got !== want) $display("FAIL single_idle: got %b want %b", got, want);
        else n_pass++;
    endtask

    task automatic test_drop_at_grant();
        logic [8:0] got;
        logic [8:0] want;
        do_reset(4'b0);
        step();
        step();
        req = 4'b0001;
        step();
        req  = 4'b0;
        got  = obs(0);
        want = pack_vec(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (got !== want) $display("FAIL dropgrant_grant: got %b want %b", got, want);
        else n_pass++;
        step();
        got  = obs(0);
        want = pack_vec(4'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (got !== want) $display("FAIL dropgrant_gap: got %b want %b", got, want);
        else n_pass++;
        step();
        got  = obs(0);
        want = pack_vec(4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got !== want) $display("FAIL dropgrant_idle: got %b want %b", got, want);
        else n_pass++;
    endtask

    // Owner 1 released by done[1]; non-owner done/req changes must not matter.
    task automatic test_done_release();
        logic [8:0] got;
        logic [8:0] want;
        do_reset(4'b0);
        step();
        step();
        req = 4'b0010;
        step();
        for (int c = 1; c <= 4; c++) begin
            data_in = (c % 2 == 1) ? 4'b0010 : 4'b0000;
            if (c == 2) begin
                req  = 4'b1010;
                done = 4'b1001;
            end
            if (c == 3) done = 4'b0;
            if (c == 4) done = 4'b0010;
            #1;
            got  = obs(0);
            want = pack_vec(4'b0010, 2'd1, 1'b1, 1'b0, (c % 2 == 1));
            n_checks++;
            if (got !== want) $display("FAIL done_grant c%0d: got %b want %b", c, got, want);
            else n_pass++;
            step();
        end
        done    = 4'b0;
        data_in = 4'b1010;
        #1;
        got  = obs(0);
        want = pack_vec(4'b0, 2'd1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (got !== want) $display("FAIL done_gap: got %b want %b", got, want);
        else n_pass++;
        step();
        got  = obs(0);
        want = pack_vec(4'b0, 2'd1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got !== want) $display("FAIL done_idle: got %b want %b", got, want);
        else n_pass++;
        step();
        got  = obs(0);
        want = pack_vec(4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (got !== want) $display("FAIL done_next_owner: got %b want %b", got, want);
        else n_pass++;
        req = 4'b0;
    endtask

    task automatic test_reset_mid_grant();
        logic [8:0] got;
        logic [8:0] want;
        do_reset(4'b0);
        step();
        step();
        req     = 4'b0100;
        data_in = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            step();
            got  = obs(0);
            want = pack_vec(4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
            n_checks++;
            if (got !== want) $display("FAIL midrst_grant c%0d: got %b want %b", c, got, want);
            else n_pass++;
        end
        #2;
        rst_n = 1'b0;
        req   = 4'b0101;
        #1;
        got  = obs(0);
        want = pack_vec(4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got !== want) $display("FAIL midrst_async: got %b want %b", got, want);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        got  = obs(0);
        want = pack_vec(4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got !== want) $display("FAIL midrst_first_edge: got %b want %b", got, want);
        else n_pass++;
        step();
        got  = obs(0);
        want = pack_vec(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (got !== want) $display("FAIL midrst_winner: got %b want %b", got, want);
        else n_pass++;
        req = 4'b0;
    endtask

    // MAX_HOLD=2: done on the expiry edge must suppress preempt.
    task automatic test_precedence();
        logic [8:0] got;
        logic [8:0] want;
        do_reset(4'b0);
        step();
        step();
        req = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            step();
            got  = obs(1);
            want = pack_vec(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (got !== want) $display("FAIL prec_grant c%0d: got %b want %b", c, got, want);
            else n_pass++;
        end
        done = 4'b0001;
        step();
        done = 4'b0;
        got  = obs(1);
        want = pack_vec(4'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (got !== want) $display("FAIL prec_gap: got %b want %b", got, want);
        else n_pass++;
        req = 4'b0;
        step();
        got  = obs(1);
        want = pack_vec(4'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (got !== want) $display("FAIL prec_idle: got %b want %b", got, want);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rotation(1'b0, 8, 4, 4'b1111, 5);
        test_single_drop();
        test_drop_at_grant();
        test_done_release();
        test_reset_mid_grant();
        test_rotation(1'b1, 2, 2, 4'b0011, 4);
        test_precedence();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

endmodule : tb_rr_mux_arbiter
